// File: rtl/layer_stage_array.sv
// Per-channel z vector buffers feeding one shared MAC; one saturated, rescaled dot product per channel.
// Optional build macro LAYER_STAGE_RELU_EN: negative results are written as 0.
module layer_stage_array #(
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 16,
  parameter int OUT_ADDR_W = 3
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       en,
  input  logic [NUM_CH*DATA_W-1:0]   z_element,
  input  logic [NUM_CH-1:0]          z_element_ready,
  output logic                       m_element_requested,
  input  logic                       m_element_ready,
  input  logic signed [DATA_W-1:0]   m_element,
  output logic signed [DATA_W-1:0]   output_ram_data,
  output logic [OUT_ADDR_W-1:0]      output_ram_address,
  output logic                       output_ram_write,
  output logic                       output_ram_enable,
  output logic                       busy,
  output logic                       overflow,
  output logic                       finished
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 2*DATA_W + IDX_W;

  typedef enum logic [2:0] {S_FILL, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PTR_W-1:0]           r_ptr [NUM_CH];
  logic signed [DATA_W-1:0]   r_cache [NUM_CH][DEPTH];
  logic [NUM_CH-1:0]          w_full;
  logic [NUM_CH-1:0]          w_wr;
  logic [CH_W-1:0]            r_ch;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [DATA_W-1:0]   r_z_p0;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [DATA_W-1:0]   w_result;
  logic                       r_overflow;
  logic                       w_consume;

  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_BITS;
    if (s[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){s[ACC_W-1]}})
      return s[DATA_W-1:0];
    else if (s[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef LAYER_STAGE_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    w_full = '0;
    w_wr   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c] = (r_ptr[c] == PTR_W'(DEPTH));
      w_wr[c]   = (r_state == S_FILL) && z_element_ready[c] && !w_full[c];
    end
  end

  // Fill stage: independent write pointer per channel
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int c = 0; c < NUM_CH; c++) r_ptr[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_wr[c]) r_ptr[c] <= r_ptr[c] + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++)
      if (w_wr[c]) r_cache[c][r_ptr[c][IDX_W-1:0]] <= z_element[c*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock) begin
    if (clear)
      r_overflow <= 1'b0;
    else if ((r_state == S_FILL) && |(z_element_ready & w_full))
      r_overflow <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (clear) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  assign w_consume = (r_state == S_MAC) && en && m_element_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (&w_full) w_state_nxt = S_FETCH;
      S_FETCH: if (en) w_state_nxt = S_MAC;
      S_MAC:   if (w_consume)
                 w_state_nxt = (r_idx == IDX_W'(DEPTH-1)) ? S_WRITE : S_FETCH;
      S_WRITE: if (en)
                 w_state_nxt = (r_ch == CH_W'(NUM_CH-1)) ? S_DONE : S_FETCH;
      default: w_state_nxt = r_state;
    endcase
  end

  // Stage p0: one-cycle cache read issued in FETCH
  always_ff @(posedge clock) begin
    if ((r_state == S_FETCH) && en) r_z_p0 <= r_cache[r_ch][r_idx];
  end

  assign w_prod = (2*DATA_W)'(r_z_p0) * (2*DATA_W)'(m_element);

  // MAC / write-back: everything frozen while en is low
  always_ff @(posedge clock) begin
    if (clear) begin
      r_ch  <= '0;
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_consume) begin
      r_acc <= r_acc + ACC_W'(w_prod);
      if (r_idx != IDX_W'(DEPTH-1)) r_idx <= r_idx + IDX_W'(1);
    end else if ((r_state == S_WRITE) && en) begin
      r_acc <= '0;
      r_idx <= '0;
      if (r_ch != CH_W'(NUM_CH-1)) r_ch <= r_ch + CH_W'(1);
    end
  end

  assign w_result = relu(sat_shift(r_acc));

  always_comb begin
    m_element_requested = 1'b0;
    output_ram_write    = 1'b0;
    output_ram_enable   = 1'b0;
    output_ram_data     = '0;
    output_ram_address  = '0;
    busy                = 1'b0;
    finished            = 1'b0;
    overflow            = r_overflow;
    case (r_state)
      S_FETCH: busy = 1'b1;
      S_MAC: begin
        busy                = 1'b1;
        m_element_requested = en;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (en) begin
          output_ram_write   = 1'b1;
          output_ram_enable  = 1'b1;
          output_ram_data    = w_result;
          output_ram_address = OUT_ADDR_W'(r_ch);
        end
      end
      S_DONE:  finished = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_layer_stage_array.sv
// Directed bench for layer_stage_array: fill patterns, saturation, stalls, overflow and mid-run clear.
module tb_layer_stage_array;
  localparam int DATA_W     = 16;
  localparam int NUM_CH     = 4;
  localparam int DEPTH      = 16;
  localparam int OUT_ADDR_W = 3;

  logic                     clock = 1'b0;
  logic                     clear;
  logic                     en;
  logic [NUM_CH*DATA_W-1:0] z_element;
  logic [NUM_CH-1:0]        z_element_ready;
  logic                     m_element_requested;
  logic                     m_element_ready;
  logic [DATA_W-1:0]        m_element;
  logic [DATA_W-1:0]        output_ram_data;
  logic [OUT_ADDR_W-1:0]    output_ram_address;
  logic                     output_ram_write;
  logic                     output_ram_enable;
  logic                     busy;
  logic                     overflow;
  logic                     finished;

  int          tests = 0;
  int          fails = 0;
  int          k_cons;
  int          nwr;
  int          viol;
  logic [15:0] cap [8];
  int          zcnt [NUM_CH];
  int          z_kind;
  logic [15:0] z_const;
  int          m_kind;
  logic [15:0] m_const;
  int          cyc;
  logic [15:0] exp_neg;

  always #5 clock = ~clock;

  layer_stage_array #(
    .DATA_W(DATA_W), .FRAC_BITS(8), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .OUT_ADDR_W(OUT_ADDR_W)
  ) dut (
    .clock(clock), .clear(clear), .en(en),
    .z_element(z_element), .z_element_ready(z_element_ready),
    .m_element_requested(m_element_requested), .m_element_ready(m_element_ready),
    .m_element(m_element),
    .output_ram_data(output_ram_data), .output_ram_address(output_ram_address),
    .output_ram_write(output_ram_write), .output_ram_enable(output_ram_enable),
    .busy(busy), .overflow(overflow), .finished(finished)
  );

  function automatic logic [15:0] zval(input int i);
    return (z_kind == 0) ? z_const : 16'(i + 1);
  endfunction

  function automatic logic [15:0] mval(input int k);
    if (m_kind == 0) return m_const;
    return ((k % DEPTH) % 2 == 0) ? 16'h0100 : 16'h0200;
  endfunction

  always @(negedge clock) begin
    if (m_element_requested && m_element_ready) k_cons++;
    if (output_ram_write) begin
      cap[output_ram_address] = output_ram_data;
      nwr++;
    end
    if (output_ram_enable !== output_ram_write) viol++;
    if (!en && (m_element_requested || output_ram_write)) viol++;
    if (!output_ram_write && (output_ram_data !== 16'h0 || output_ram_address !== 3'h0)) viol++;
  end

  task automatic clear_model();
    k_cons = 0;
    nwr    = 0;
    viol   = 0;
    for (int c = 0; c < 8; c++) cap[c] = 16'hDEAD;
    for (int c = 0; c < NUM_CH; c++) zcnt[c] = 0;
  endtask

  task automatic do_reset();
    clear = 1'b1; en = 1'b0; z_element = '0; z_element_ready = '0;
    m_element_ready = 1'b0; m_element = '0;
    @(posedge clock); #1;
    clear = 1'b0;
    clear_model();
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] mask);
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        z_element[c*DATA_W +: DATA_W] = zval(zcnt[c]);
        if (zcnt[c] < DEPTH) zcnt[c]++;
      end
    end
    z_element_ready = mask;
    @(posedge clock); #1;
    z_element_ready = '0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) strobe(4'b1111);
  endtask

  // mode 0: en high, ready tied high; mode 1: en low 5 cycles, random ready gaps
  task automatic run_compute(input int mode, input int stop_k, output int cycles);
    cycles = 0;
    en = 1'b1; m_element_ready = 1'b1; m_element = mval(k_cons);
    while (!finished && cycles < 2000 && !(stop_k >= 0 && k_cons >= stop_k)) begin
      @(posedge clock); #1;
      cycles++;
      m_element = mval(k_cons);
      if (mode == 1) begin
        en = !(cycles >= 40 && cycles < 45);
        m_element_ready = ($urandom_range(0, 3) != 0);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({busy, finished, overflow, output_ram_write, output_ram_enable, m_element_requested} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 000000",
        {busy, finished, overflow, output_ram_write, output_ram_enable, m_element_requested});
    end
    tests++;
    if (output_ram_data !== 16'h0) begin
      fails++; $display("FAIL reset_data: got %h expected 0000", output_ram_data);
    end
    tests++;
    if (output_ram_address !== 3'h0) begin
      fails++; $display("FAIL reset_addr: got %h expected 0", output_ram_address);
    end
  endtask

  task automatic test_basic();
    do_reset();
    z_kind = 0; z_const = 16'h0100; m_kind = 0; m_const = 16'h0200;
    fill_all();
    run_compute(0, -1, cyc);
    tests++;
    if (finished !== 1'b1 || cyc !== 133) begin
      fails++; $display("FAIL basic_latency: got finished=%b cycles=%0d expected 1/133", finished, cyc);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      tests++;
      if (cap[c] !== 16'h2000) begin
        fails++; $display("FAIL basic_word%0d: got %h expected 2000", c, cap[c]);
      end
    end
    repeat (5) @(posedge clock);
    #1;
    tests++;
    if (nwr !== NUM_CH || finished !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_done_hold: got writes=%0d finished=%b busy=%b expected 4/1/0", nwr, finished, busy);
    end
  endtask

  task automatic test_interleaved();
    do_reset();
    z_kind = 1; m_kind = 0; m_const = 16'h0100;
    for (int i = 0; i < DEPTH; i++) begin
      strobe(4'b0101);
      strobe(4'b0010);
      @(posedge clock); #1;
      strobe(4'b1000);
    end
    run_compute(0, -1, cyc);
    for (int c = 0; c < NUM_CH; c++) begin
      tests++;
      if (cap[c] !== 16'h0088) begin
        fails++; $display("FAIL interleaved_word%0d: got %h expected 0088", c, cap[c]);
      end
    end
    tests++;
    if (overflow !== 1'b0 || viol !== 0) begin
      fails++; $display("FAIL interleaved_flags: got overflow=%b viol=%0d expected 0/0", overflow, viol);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    z_kind = 1; m_kind = 0; m_const = 16'h0100;
    for (int i = 0; i < DEPTH; i++) strobe(4'b0100);
    tests++;
    if (overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_before: got %b expected 0", overflow);
    end
    strobe(4'b0100);
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < DEPTH; i++) strobe(4'b1011);
    run_compute(0, -1, cyc);
    tests++;
    if (cap[2] !== 16'h0088 || cap[0] !== 16'h0088) begin
      fails++; $display("FAIL ovf_results: got w0=%h w2=%h expected 0088/0088", cap[0], cap[2]);
    end
    tests++;
    if (overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    z_kind = 0; z_const = 16'h7FFF; m_kind = 0; m_const = 16'h7FFF;
    fill_all();
    run_compute(0, -1, cyc);
    tests++;
    if (cap[0] !== 16'h7FFF || cap[3] !== 16'h7FFF) begin
      fails++; $display("FAIL sat_pos: got w0=%h w3=%h expected 7fff", cap[0], cap[3]);
    end
`ifdef LAYER_STAGE_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8000;
`endif
    do_reset();
    z_const = 16'h8000;
    fill_all();
    run_compute(0, -1, cyc);
    tests++;
    if (cap[1] !== exp_neg || cap[2] !== exp_neg) begin
      fails++; $display("FAIL sat_neg: got w1=%h w2=%h expected %h", cap[1], cap[2], exp_neg);
    end
  endtask

  task automatic test_stall();
    do_reset();
    z_kind = 1; m_kind = 1;
    fill_all();
    run_compute(0, -1, cyc);
    for (int c = 0; c < NUM_CH; c++) begin
      tests++;
      if (cap[c] !== 16'h00D0) begin
        fails++; $display("FAIL stall_ref_word%0d: got %h expected 00d0", c, cap[c]);
      end
    end
    do_reset();
    fill_all();
    run_compute(1, -1, cyc);
    tests++;
    if (finished !== 1'b1) begin
      fails++; $display("FAIL stall_finish: got %b expected 1 (cycles=%0d)", finished, cyc);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      tests++;
      if (cap[c] !== 16'h00D0) begin
        fails++; $display("FAIL stall_word%0d: got %h expected 00d0", c, cap[c]);
      end
    end
    tests++;
    if (viol !== 0 || nwr !== NUM_CH) begin
      fails++; $display("FAIL stall_protocol: got viol=%0d writes=%0d expected 0/4", viol, nwr);
    end
  endtask

  task automatic test_clear_mid();
    do_reset();
    z_kind = 0; z_const = 16'h0100; m_kind = 0; m_const = 16'h0200;
    for (int i = 0; i < DEPTH; i++) strobe(4'b0001);
    strobe(4'b0001);
    for (int i = 0; i < DEPTH; i++) strobe(4'b1110);
    run_compute(0, DEPTH + 7, cyc);
    tests++;
    if (busy !== 1'b1 || overflow !== 1'b1) begin
      fails++; $display("FAIL clear_pre: got busy=%b overflow=%b expected 1/1", busy, overflow);
    end
    clear = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({busy, finished, overflow, output_ram_write, output_ram_enable, m_element_requested,
         output_ram_data, output_ram_address} !== 25'h0) begin
      fails++; $display("FAIL clear_outputs: got busy=%b fin=%b ovf=%b wr=%b en=%b req=%b data=%h addr=%h expected all 0",
        busy, finished, overflow, output_ram_write, output_ram_enable, m_element_requested,
        output_ram_data, output_ram_address);
    end
    clear = 1'b0;
    clear_model();
    fill_all();
    run_compute(0, -1, cyc);
    tests++;
    if (finished !== 1'b1 || cyc !== 133) begin
      fails++; $display("FAIL clear_rerun_latency: got finished=%b cycles=%0d expected 1/133", finished, cyc);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      tests++;
      if (cap[c] !== 16'h2000) begin
        fails++; $display("FAIL clear_rerun_word%0d: got %h expected 2000", c, cap[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleaved();
    test_overflow();
    test_saturation();
    test_stall();
    test_clear_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_stage_array.md
Name: layer_stage_array

Overview:
- Parametrised successor to the fixed 4-channel, 16-deep second stage of the network datapath.
- Buffers NUM_CH independent z vectors of DEPTH signed fixed-point elements, each arriving on its own strobe.
- Once every channel is full, computes one dot product per channel against a streamed m (weight) vector, using a single multiply-accumulate (MAC) unit.
- Writes each saturated, rescaled result to the output RAM at address = channel index.

Parameters:
DATA_W, 16, element width (signed two's complement)
FRAC_BITS, 8, fractional bits of the fixed-point format
NUM_CH, 4, number of z channels / output words (>=1)
DEPTH, 16, elements per z vector (>=2, power of two)
OUT_ADDR_W, 3, output RAM address width (>= clog2(NUM_CH))

Ports:
clock  in  1  single clock, rising edge
clear  in  1  synchronous active-high reset
en  in  1  compute enable; low stalls compute phase
z_element  in  NUM_CH*DATA_W  packed z inputs, channel c at [c*DATA_W +: DATA_W]
z_element_ready  in  NUM_CH  per-channel write strobe
m_element_requested  out  1  level request for the next m element
m_element_ready  in  1  m_element valid this cycle
m_element  in  DATA_W  weight element
output_ram_data  out  DATA_W  result word
output_ram_address  out  OUT_ADDR_W  result address (channel index)
output_ram_write  out  1  write strobe
output_ram_enable  out  1  RAM enable (equals output_ram_write)
busy  out  1  compute phase active
overflow  out  1  sticky: write attempted to a full channel
finished  out  1  sticky: all NUM_CH results written

Behaviour:
- Reset (clear=1 at a clock edge): all fill counters 0, FSM=FILL, accumulator 0, all outputs 0. Reset is honoured in any state, including mid-compute. Cache contents are don't-care after reset.
- FILL:
  - Each channel has its own write pointer. z_element_ready[c] writes element c at pointer[c], then increments the pointer.
  - Simultaneous strobes on any subset of channels are all accepted in the same cycle.
  - A strobe to a channel holding DEPTH elements is dropped and sets overflow.
  - Exit to FETCH the cycle after all channels are full. en is not required in FILL.
- FETCH: issues the cache read for channel ch, index i. Read latency is 1 cycle. Then go to MAC.
- MAC:
  - m_element_requested=1 while en=1.
  - An element is consumed on a cycle with m_element_ready=1 and m_element_requested=1: acc += z*m, using a full 2*DATA_W product and an accumulator of 2*DATA_W+clog2(DEPTH) bits.
  - m_element_ready while not requested is ignored.
  - After consumption: if i<DEPTH-1, i++ and go to FETCH; otherwise go to WRITE.
- WRITE (1 cycle):
  - result = acc >>> FRAC_BITS (arithmetic), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - output_ram_write = output_ram_enable = 1, output_ram_address = ch.
  - acc and i cleared. If ch=NUM_CH-1, go to DONE; otherwise ch++ and go to FETCH.
- DONE: finished=1 and busy=0, held until clear. All z and m inputs are ignored.
- Stall: when en=0 in FETCH/MAC/WRITE, no state, counter or accumulator changes; requested=0 and write=0. The operation resumes exactly where it stopped.
- busy=1 in FETCH, MAC and WRITE.
- Minimum compute latency, from FILL exit to finished: NUM_CH*(2*DEPTH+1)+1 cycles, with m_element_ready tied high and en=1.
- Output RAM data, address and write change only in WRITE and are 0 otherwise.

Optional Feature:
- Macro LAYER_STAGE_RELU_EN.
- Defined: a ReLU is applied after saturation, so negative results are written as 0.
- Undefined: the signed saturated result is written unchanged.
- Latency is identical in both builds.

Test Plan:
- Defaults; all z=0x0100 (1.0), all m=0x0200 (2.0), en=1, ready tied high -> words 0..3 = 0x2000 (32.0); finished rises 4*33+1 cycles after the last fill write.
- Channels filled interleaved and simultaneously with z[c][i]=i+1 (raw), m=0x0100 -> word c = 136 raw (0x0088) for every c; overflow stays 0.
- One extra strobe to a full channel 2 -> overflow=1; results unchanged.
- z=0x7FFF, m=0x7FFF -> word = 0x7FFF (positive saturation). z=0x8000, m=0x7FFF -> 0x8000 without RELU_EN, 0x0000 with it.
- Toggle en low for 5 cycles mid-MAC and hold m_element_ready low for random gaps -> results identical to the uninterrupted run; no request while en=0.
- Assert clear at channel 1, index 7 -> all outputs 0 the next cycle; a full refill and rerun gives correct results.
